// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read port between the instruction cache (s0)
// and the data cache (s1); each burst stays locked to its owner until rlast.
module axi_read_arbiter #(
    parameter int addr_width = 64,
    parameter int data_width = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  s0_arvalid,
    input  logic [addr_width-1:0] s0_araddr,
    input  logic [7:0]            s0_arlen,
    input  logic [2:0]            s0_arsize,
    input  logic [1:0]            s0_arburst,
    output logic                  s0_arready,
    output logic                  s0_rvalid,
    output logic [data_width-1:0] s0_rdata,
    output logic                  s0_rlast,
    input  logic                  s0_rready,

    input  logic                  s1_arvalid,
    input  logic [addr_width-1:0] s1_araddr,
    input  logic [7:0]            s1_arlen,
    input  logic [2:0]            s1_arsize,
    input  logic [1:0]            s1_arburst,
    output logic                  s1_arready,
    output logic                  s1_rvalid,
    output logic [data_width-1:0] s1_rdata,
    output logic                  s1_rlast,
    input  logic                  s1_rready,

    output logic                  m_axi_arvalid,
    output logic [addr_width-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rvalid,
    input  logic [data_width-1:0] m_axi_rdata,
    input  logic                  m_axi_rlast,
    output logic                  m_axi_rready,

    output logic                  burst_error
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                r_state;
    logic                  r_prio;
    logic                  r_owner;
    logic [8:0]            r_beatCnt;
    logic [addr_width-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_burstError;

    logic w_idle;
    logic w_data;
    logic w_grant0;
    logic w_grant1;
    logic w_rHandshake;
    logic w_lenMatch;
    logic w_to0;
    logic w_to1;

    // r_prio names the requester that wins when both ask in the same IDLE cycle
    assign w_grant0     = s0_arvalid && (!s1_arvalid || !r_prio);
    assign w_grant1     = s1_arvalid && (!s0_arvalid ||  r_prio);
    assign w_idle       = (r_state == IDLE);
    assign w_data       = (r_state == DATA);
    assign w_to0        = w_data && !r_owner;
    assign w_to1        = w_data &&  r_owner;
    assign w_rHandshake = w_data && m_axi_rvalid && m_axi_rready;
    assign w_lenMatch   = (r_beatCnt == {1'b0, r_len});

    assign s0_arready = w_idle && w_grant0;
    assign s1_arready = w_idle && w_grant1;

    assign m_axi_arvalid = (r_state == ADDR);
    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = r_len;
    assign m_axi_arsize  = r_size;
    assign m_axi_arburst = r_burst;

    assign s0_rvalid = w_to0 && m_axi_rvalid;
    assign s0_rdata  = w_to0 ? m_axi_rdata : '0;
    assign s0_rlast  = w_to0 && m_axi_rlast;
    assign s1_rvalid = w_to1 && m_axi_rvalid;
    assign s1_rdata  = w_to1 ? m_axi_rdata : '0;
    assign s1_rlast  = w_to1 && m_axi_rlast;

    assign m_axi_rready = w_data && (r_owner ? s1_rready : s0_rready);
    assign burst_error  = r_burstError;

    // Burst length is checked on every beat, but only rlast ever ends the burst
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_prio       <= 1'b0;
            r_owner      <= 1'b0;
            r_beatCnt    <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= '0;
            r_burstError <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_owner <= w_grant1;
                        r_addr  <= w_grant1 ? s1_araddr  : s0_araddr;
                        r_len   <= w_grant1 ? s1_arlen   : s0_arlen;
                        r_size  <= w_grant1 ? s1_arsize  : s0_arsize;
                        r_burst <= w_grant1 ? s1_arburst : s0_arburst;
                        r_state <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi_arready) begin
                        r_beatCnt <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_rHandshake) begin
                        if (r_beatCnt != 9'd511) begin
                            r_beatCnt <= r_beatCnt + 9'd1;
                        end
                        if (m_axi_rlast != w_lenMatch) begin
                            r_burstError <= 1'b1;
                        end
                        if (m_axi_rlast) begin
                            r_prio  <= ~r_owner;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: fills, round-robin arbitration, backpressure,
// length-mismatch detection and reset in the middle of a burst.
module tb_axi_read_arbiter;

    logic        clock;
    logic        reset_n;
    logic        s0_arvalid, s1_arvalid;
    logic [63:0] s0_araddr, s1_araddr;
    logic [7:0]  s0_arlen, s1_arlen;
    logic [2:0]  s0_arsize, s1_arsize;
    logic [1:0]  s0_arburst, s1_arburst;
    logic        s0_arready, s1_arready;
    logic        s0_rvalid, s1_rvalid;
    logic [63:0] s0_rdata, s1_rdata;
    logic        s0_rlast, s1_rlast;
    logic        s0_rready, s1_rready;
    logic        m_axi_arvalid;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arready;
    logic        m_axi_rvalid;
    logic [63:0] m_axi_rdata;
    logic        m_axi_rlast;
    logic        m_axi_rready;
    logic        burst_error;

    int checks = 0;
    int errors = 0;

    axi_read_arbiter #(.addr_width(64), .data_width(64)) dut (
        .clock(clock), .reset_n(reset_n),
        .s0_arvalid(s0_arvalid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
        .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arready(s0_arready),
        .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata), .s0_rlast(s0_rlast), .s0_rready(s0_rready),
        .s1_arvalid(s1_arvalid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
        .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arready(s1_arready),
        .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata), .s1_rlast(s1_rlast), .s1_rready(s1_rready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
        .m_axi_rready(m_axi_rready), .burst_error(burst_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change 1 ns after the rising edge, outputs are sampled 1 ns later
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int n, input logic valid, input logic [63:0] addr, input logic [7:0] len);
        if (n == 0) begin
            s0_arvalid = valid; s0_araddr = addr; s0_arlen = len; s0_arsize = 3'd3; s0_arburst = 2'd2;
        end else begin
            s1_arvalid = valid; s1_araddr = addr; s1_arlen = len; s1_arsize = 3'd3; s1_arburst = 2'd1;
        end
    endtask

    function automatic logic [63:0] beatData(input int owner, input int i);
        return 64'(i + 1) * 64'h11 + 64'(owner) * 64'h100;
    endfunction

    // Raise owner's request in an IDLE cycle, expect an immediate grant, then run
    // the AR handshake after waitCycles of memory backpressure
    task automatic addrPhase(input int owner, input logic [63:0] addr, input logic [7:0] len, input int waitCycles);
        applyStimulus(owner, 1'b1, addr, len);
        #1;
        checkOutput("grant_own", owner == 0 ? 64'(s0_arready) : 64'(s1_arready), 64'd1);
        checkOutput("grant_other", owner == 0 ? 64'(s1_arready) : 64'(s0_arready), 64'd0);
        checkOutput("arvalid_idle", 64'(m_axi_arvalid), 64'd0);
        tick();
        if (owner == 0) s0_arvalid = 1'b0; else s1_arvalid = 1'b0;
        for (int w = 0; w < waitCycles; w++) begin
            #1;
            checkOutput("ar_wait_valid", 64'(m_axi_arvalid), 64'd1);
            checkOutput("ar_wait_addr", m_axi_araddr, addr);
            checkOutput("ar_wait_len", 64'(m_axi_arlen), 64'(len));
            tick();
        end
        m_axi_arready = 1'b1;
        #1;
        checkOutput("ar_valid", 64'(m_axi_arvalid), 64'd1);
        checkOutput("ar_addr", m_axi_araddr, addr);
        checkOutput("ar_len", 64'(m_axi_arlen), 64'(len));
        checkOutput("arready_busy", 64'({s0_arready, s1_arready}), 64'd0);
        tick();
        m_axi_arready = 1'b0;
        #1;
        checkOutput("ar_drop", 64'(m_axi_arvalid), 64'd0);
    endtask

    // Memory returns beats 0..rlastAt with rlast on the final one; the owner's
    // rready may be dropped for stallCycles while beat stallAt is on the bus
    task automatic memBurst(input int owner, input int rlastAt, input int stallAt, input int stallCycles);
        if (owner == 0) s0_rready = 1'b1; else s1_rready = 1'b1;
        for (int i = 0; i <= rlastAt; i++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = beatData(owner, i);
            m_axi_rlast  = (i == rlastAt);
            if (i == stallAt) begin
                for (int s = 0; s < stallCycles; s++) begin
                    if (owner == 0) s0_rready = 1'b0; else s1_rready = 1'b0;
                    #1;
                    checkOutput("stall_rready", 64'(m_axi_rready), 64'd0);
                    checkOutput("stall_rdata", owner == 0 ? s0_rdata : s1_rdata, beatData(owner, i));
                    tick();
                end
                if (owner == 0) s0_rready = 1'b1; else s1_rready = 1'b1;
            end
            #1;
            checkOutput("r_valid", owner == 0 ? 64'(s0_rvalid) : 64'(s1_rvalid), 64'd1);
            checkOutput("r_data", owner == 0 ? s0_rdata : s1_rdata, beatData(owner, i));
            checkOutput("r_last", owner == 0 ? 64'(s0_rlast) : 64'(s1_rlast), 64'(i == rlastAt));
            checkOutput("r_other", owner == 0 ? 64'(s1_rvalid) : 64'(s0_rvalid), 64'd0);
            checkOutput("m_rready", 64'(m_axi_rready), 64'd1);
            tick();
        end
        m_axi_rvalid = 1'b0;
        m_axi_rdata  = '0;
        m_axi_rlast  = 1'b0;
        s0_rready    = 1'b0;
        s1_rready    = 1'b0;
    endtask

    task automatic applyReset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        s0_arvalid = 0; s0_araddr = '0; s0_arlen = '0; s0_arsize = '0; s0_arburst = '0; s0_rready = 0;
        s1_arvalid = 0; s1_araddr = '0; s1_arlen = '0; s1_arsize = '0; s1_arburst = '0; s1_rready = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rlast = 0;
        tick();
        checkOutput("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        checkOutput("rst_araddr", m_axi_araddr, 64'd0);
        checkOutput("rst_rready", 64'(m_axi_rready), 64'd0);
        checkOutput("rst_error", 64'(burst_error), 64'd0);
        tick();
        reset_n = 1'b1;

        $display("[TB] single icache fill");
        addrPhase(0, 64'h1000, 8'd7, 0);
        checkOutput("fill_size", 64'(m_axi_arsize), 64'd3);
        checkOutput("fill_burst", 64'(m_axi_arburst), 64'd2);
        memBurst(0, 7, -1, 0);
        #1;
        checkOutput("fill_error", 64'(burst_error), 64'd0);
        checkOutput("fill_idle", 64'(m_axi_arvalid), 64'd0);

        $display("[TB] simultaneous requests after reset");
        applyReset();
        applyStimulus(1, 1'b1, 64'h3000, 8'd0);
        addrPhase(0, 64'h2000, 8'd0, 0);
        memBurst(0, 0, -1, 0);
        addrPhase(1, 64'h3000, 8'd0, 0);
        memBurst(1, 0, -1, 0);
        applyStimulus(1, 1'b1, 64'h5000, 8'd3);

        $display("[TB] AR and R backpressure");
        addrPhase(0, 64'h4000, 8'd0, 5);
        memBurst(0, 0, -1, 0);
        addrPhase(1, 64'h5000, 8'd3, 0);
        memBurst(1, 3, 2, 3);
        #1;
        checkOutput("bp_error", 64'(burst_error), 64'd0);

        $display("[TB] length mismatch");
        addrPhase(0, 64'h6000, 8'd7, 0);
        memBurst(0, 3, -1, 0);
        #1;
        checkOutput("mm_error", 64'(burst_error), 64'd1);
        addrPhase(1, 64'h7000, 8'd1, 0);
        memBurst(1, 1, -1, 0);
        #1;
        checkOutput("mm_sticky", 64'(burst_error), 64'd1);

        $display("[TB] reset mid-burst");
        addrPhase(1, 64'h8000, 8'd7, 0);
        s1_rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = beatData(1, i);
            #1;
            checkOutput("mid_rdata", s1_rdata, beatData(1, i));
            tick();
        end
        m_axi_rdata = beatData(1, 3);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_rvalid", 64'(s1_rvalid), 64'd0);
        checkOutput("mid_rst_rdata", s1_rdata, 64'd0);
        checkOutput("mid_rst_rready", 64'(m_axi_rready), 64'd0);
        checkOutput("mid_rst_araddr", m_axi_araddr, 64'd0);
        checkOutput("mid_rst_error", 64'(burst_error), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        checkOutput("post_rst_rready", 64'(m_axi_rready), 64'd0);
        checkOutput("post_rst_rvalid", 64'(s1_rvalid), 64'd0);
        m_axi_rvalid = 1'b0;
        m_axi_rdata  = '0;
        s1_rready    = 1'b0;
        addrPhase(1, 64'h9000, 8'd0, 0);
        memBurst(1, 0, -1, 0);
        #1;
        checkOutput("final_error", 64'(burst_error), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Two-requester arbiter that shares the core's single AXI read port between the instruction cache (requester 0) and the data cache (requester 1). It accepts one line-fill read request at a time, forwards it to the AXI AR channel, and steers the returning R-channel burst back to the owning requester. The burst stays locked until `rlast`. Arbitration is round-robin, so neither cache can starve the other on back-to-back misses.

## Interface
Parameters:
- `addr_width`, 64, AR address width.
- `data_width`, 64, R data width.

Ports (`sN_*` exists for N = 0, 1):
- `clock`  in  1  single clock; all state on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sN_arvalid`  in  1  requester N has a read request.
- `sN_araddr`  in  addr_width  request address.
- `sN_arlen`  in  8  beats minus one.
- `sN_arsize`  in  3  bytes per beat, log2.
- `sN_arburst`  in  2  burst type, passed through unchanged.
- `sN_arready`  out  1  request accepted (one-cycle pulse).
- `sN_rvalid`  out  1  beat valid for requester N.
- `sN_rdata`  out  data_width  beat data.
- `sN_rlast`  out  1  last beat.
- `sN_rready`  in  1  requester N accepts the beat.
- `m_axi_arvalid`, `m_axi_araddr`, `m_axi_arlen`, `m_axi_arsize`, `m_axi_arburst`  out  AR channel to memory.
- `m_axi_arready`  in  1  memory accepts the address.
- `m_axi_rvalid`, `m_axi_rdata`, `m_axi_rlast`  in  R channel from memory.
- `m_axi_rready`  out  1  ready toward memory.
- `burst_error`  out  1  sticky flag: the `rlast` position did not match the latched `arlen`.

## Operation
- States: IDLE, ADDR, DATA.
- **IDLE**
  - If exactly one `sN_arvalid` is high, grant requester N.
  - If both are high, grant the requester selected by the priority pointer `prio`.
  - On a grant: `sN_arready`=1 combinationally in that cycle; latch addr, len, size and burst; `owner`<=N; next state ADDR.
  - No request: stay in IDLE.
- **ADDR**
  - `m_axi_arvalid`=1 with the latched fields, held stable until `m_axi_arready`.
  - On `m_axi_arready`: next state DATA; `beat_cnt`<=0.
- **DATA**
  - Owner N receives `sN_rvalid`=`m_axi_rvalid`, plus `sN_rdata` and `sN_rlast` forwarded combinationally.
  - `m_axi_rready`=`sN_rready` of the owner.
  - The non-owner sees `rvalid`=0, `rdata`=0, `rlast`=0.
  - Each beat handshake (`m_axi_rvalid`&&`m_axi_rready`) increments `beat_cnt` (9-bit, saturating at 511).
  - A handshake with `m_axi_rlast`=1 ends the burst: next state IDLE and `prio`<=~`owner`.
- **Error check, on every handshake**
  - Set `burst_error` if `rlast`=1 and `beat_cnt`!=latched `arlen`.
  - Set `burst_error` if `rlast`=0 and `beat_cnt`==latched `arlen`.
  - The burst still terminates only on `rlast`.
  - `burst_error` clears only on reset.
- `sN_arready` is never high outside IDLE. A requester that keeps `arvalid` high waits for the next IDLE.
- Only one transaction is outstanding at a time. No AXI IDs are used.

## Timing
- Reset (`reset_n` low, asynchronous):
  - state=IDLE, `prio`=0, `owner`=0, `beat_cnt`=0, `burst_error`=0.
  - Latched fields are 0.
  - All outputs are 0: every `arvalid`, `arready`, `rvalid`, `rlast`, `rready`, `rdata` and `araddr`.
- Reset asserted mid-burst: the burst is abandoned immediately. On release the block is in IDLE and does not consume remaining beats.
- Request latency: `sN_arvalid` seen in IDLE at cycle 0 gives `sN_arready`=1 at cycle 0 and `m_axi_arvalid`=1 from cycle 1.
- R path: zero-cycle, combinational between memory and owner.
- Turnaround: the `rlast` handshake in cycle T gives IDLE in T+1. The earliest next `m_axi_arvalid` is T+2.
- `m_axi_arvalid` deasserts in the cycle after the `m_axi_arready` handshake. AR fields do not change while `m_axi_arvalid`=1.
- Simultaneous requests: the non-granted requester wins the next arbitration if it is still requesting.
- `rlast` on the first beat with `arlen`=0 is a legal single-beat burst.

## Test plan
- **Single icache fill.** s0 requests addr 0x1000, arlen=7, arsize=3, burst=2. Required: `s0_arready` pulse at cycle 0, `m_axi_araddr`=0x1000 from cycle 1. Memory returns 8 beats 0x11..0x88 with `rlast` on beat 8; s0 receives all 8 in order. `s1_rvalid` stays 0 throughout. `burst_error`=0.
- **Simultaneous requests after reset.** s0 and s1 request at the same cycle. Required: s0 granted first (`prio`=0); s1 granted on the following IDLE; a third simultaneous pair is granted to s0 again.
- **Backpressure.** `m_axi_arready` is held low for 5 cycles: AR fields stay stable. `s1_rready` is low for 3 cycles mid-burst: `m_axi_rready`=0 and no beats are lost or duplicated.
- **Length mismatch.** arlen=7 but memory asserts `rlast` on beat 4. Required: `burst_error`=1 (sticky), return to IDLE, next request proceeds normally.
- **Reset mid-burst.** `reset_n` driven low after beat 3 of 8. Required: all outputs 0 while `reset_n` is low. After release, state is IDLE and a new s1 request is accepted within 1 cycle.
